// File: rtl/mem_stage.sv
// Load/store stage: captures the EX/MEM bundle, runs one data-memory req/ready
// transaction with alignment checks and store formatting, and emits one write-back result.
module mem_stage #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick_exmem,
    input  logic [31:0] alu_result_in,
    input  logic [31:0] rs2_data_in,
    input  logic [2:0]  funct3_in,
    input  logic        mem_read_in,
    input  logic        mem_write_in,
    input  logic [4:0]  rd_in,
    input  logic        reg_write_in,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_wstrb,
    input  logic        dmem_ready,
    input  logic [31:0] dmem_rdata,
    output logic [31:0] wb_data,
    output logic [4:0]  wb_rd,
    output logic        wb_we,
    output logic        done,
    output logic        busy,
    output logic        misaligned,
    output logic        bus_err
);

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [1:0]  lane_q, lane_d;
    logic [2:0]  f3_q, f3_d;
    logic [4:0]  rd_q, rd_d;
    logic        rw_q, rw_d;
    logic        is_load_q, is_load_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic [4:0]  wb_rd_q, wb_rd_d;
    logic        wb_we_q, wb_we_d;
    logic        done_q, done_d;
    logic        mis_q, mis_d;
    logic        err_q, err_d;

    logic        in_illegal, in_misal;
    logic [31:0] st_wdata;
    logic [3:0]  st_wstrb;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_val;

    // Decode of the incoming bundle, evaluated only when a tick is accepted.
    always_comb begin
        in_illegal = (mem_read_in & mem_write_in)
                   | (mem_read_in & ((funct3_in == 3'b011) || (funct3_in[2:1] == 2'b11)))
                   | (mem_write_in & (funct3_in >= 3'b011));
        in_misal   = ((funct3_in[1:0] == 2'b01) & alu_result_in[0])
                   | ((funct3_in[1:0] == 2'b10) & (|alu_result_in[1:0]));
        case (funct3_in[1:0])
            2'b00: begin
                st_wdata = {4{rs2_data_in[7:0]}};
                st_wstrb = 4'b0001 << alu_result_in[1:0];
            end
            2'b01: begin
                st_wdata = {2{rs2_data_in[15:0]}};
                st_wstrb = alu_result_in[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                st_wdata = rs2_data_in;
                st_wstrb = 4'b1111;
            end
        endcase
    end

    always_comb begin
        ld_byte = 8'(dmem_rdata >> {lane_q, 3'b000});
        ld_half = lane_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (f3_q)
            3'b000:  ld_val = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_val = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_val = {24'd0, ld_byte};
            3'b101:  ld_val = {16'd0, ld_half};
            default: ld_val = dmem_rdata;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        lane_d    = lane_q;
        f3_d      = f3_q;
        rd_d      = rd_q;
        rw_d      = rw_q;
        is_load_d = is_load_q;
        req_d     = req_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        wb_data_d = wb_data_q;
        wb_rd_d   = wb_rd_q;
        wb_we_d   = 1'b0;
        done_d    = 1'b0;
        mis_d     = 1'b0;
        err_d     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (tick_exmem) begin
                    lane_d    = alu_result_in[1:0];
                    f3_d      = funct3_in;
                    rd_d      = rd_in;
                    rw_d      = reg_write_in;
                    is_load_d = mem_read_in;
                    if (!mem_read_in && !mem_write_in) begin
                        state_d   = S_DONE;
                        done_d    = 1'b1;
                        wb_rd_d   = rd_in;
                        wb_data_d = alu_result_in;
                        wb_we_d   = reg_write_in;
                    end else if (in_illegal || in_misal) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        wb_rd_d = rd_in;
                        err_d   = in_illegal;
                        mis_d   = !in_illegal;
                    end else begin
                        state_d = S_ACCESS;
                        cnt_d   = 8'd0;
                        req_d   = 1'b1;
                        we_d    = mem_write_in;
                        addr_d  = {alu_result_in[31:2], 2'b00};
                        wdata_d = mem_write_in ? st_wdata : 32'd0;
                        wstrb_d = mem_write_in ? st_wstrb : 4'b0000;
                    end
                end
            end
            S_ACCESS: begin
                // Ready wins over a timeout landing on the same cycle.
                if (dmem_ready || (cnt_q == TO_LAST)) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    wb_rd_d = rd_q;
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    addr_d  = 32'd0;
                    wdata_d = 32'd0;
                    wstrb_d = 4'b0000;
                    if (!dmem_ready) begin
                        err_d = 1'b1;
                    end else if (is_load_q) begin
                        wb_data_d = ld_val;
                        wb_we_d   = rw_q;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= 8'd0;
            lane_q    <= 2'd0;
            f3_q      <= 3'd0;
            rd_q      <= 5'd0;
            rw_q      <= 1'b0;
            is_load_q <= 1'b0;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= 32'd0;
            wdata_q   <= 32'd0;
            wstrb_q   <= 4'b0000;
            wb_data_q <= 32'd0;
            wb_rd_q   <= 5'd0;
            wb_we_q   <= 1'b0;
            done_q    <= 1'b0;
            mis_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            lane_q    <= lane_d;
            f3_q      <= f3_d;
            rd_q      <= rd_d;
            rw_q      <= rw_d;
            is_load_q <= is_load_d;
            req_q     <= req_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            wb_data_q <= wb_data_d;
            wb_rd_q   <= wb_rd_d;
            wb_we_q   <= wb_we_d;
            done_q    <= done_d;
            mis_q     <= mis_d;
            err_q     <= err_d;
        end
    end

    assign dmem_req   = req_q;
    assign dmem_we    = we_q;
    assign dmem_addr  = addr_q;
    assign dmem_wdata = wdata_q;
    assign dmem_wstrb = wstrb_q;
    assign wb_data    = wb_data_q;
    assign wb_rd      = wb_rd_q;
    assign wb_we      = wb_we_q;
    assign done       = done_q;
    assign busy       = (state_q != S_IDLE);
    assign misaligned = mis_q;
    assign bus_err    = err_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage with a short timeout so the abort path is reachable.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        tick_exmem;
    logic [31:0] alu_result_in;
    logic [31:0] rs2_data_in;
    logic [2:0]  funct3_in;
    logic        mem_read_in;
    logic        mem_write_in;
    logic [4:0]  rd_in;
    logic        reg_write_in;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_wstrb;
    logic        dmem_ready;
    logic [31:0] dmem_rdata;
    logic [31:0] wb_data;
    logic [4:0]  wb_rd;
    logic        wb_we;
    logic        done;
    logic        busy;
    logic        misaligned;
    logic        bus_err;

    int n_chk  = 0;
    int n_fail = 0;
    int req_cycles = 0;
    int done_pulses = 0;
    int req_base;
    int done_base;

    mem_stage #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .tick_exmem(tick_exmem),
        .alu_result_in(alu_result_in), .rs2_data_in(rs2_data_in),
        .funct3_in(funct3_in), .mem_read_in(mem_read_in),
        .mem_write_in(mem_write_in), .rd_in(rd_in), .reg_write_in(reg_write_in),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb), .dmem_ready(dmem_ready),
        .dmem_rdata(dmem_rdata), .wb_data(wb_data), .wb_rd(wb_rd), .wb_we(wb_we),
        .done(done), .busy(busy), .misaligned(misaligned), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (dmem_req) req_cycles++;
        if (done) done_pulses++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents one bundle with tick for a single edge; returns one cycle after capture.
    task automatic issue(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f3,
                         input logic rdv, input logic wrv, input logic [4:0] r, input logic rw);
        alu_result_in = a;
        rs2_data_in   = d;
        funct3_in     = f3;
        mem_read_in   = rdv;
        mem_write_in  = wrv;
        rd_in         = r;
        reg_write_in  = rw;
        tick_exmem    = 1'b1;
        req_base      = req_cycles;
        step();
        tick_exmem    = 1'b0;
    endtask

    initial begin
        rst = 1'b0; tick_exmem = 1'b0; alu_result_in = '0; rs2_data_in = '0;
        funct3_in = '0; mem_read_in = 1'b0; mem_write_in = 1'b0; rd_in = '0;
        reg_write_in = 1'b0; dmem_ready = 1'b0; dmem_rdata = '0;
        repeat (3) step();
        check("rst_done", 32'(done), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_req", 32'(dmem_req), 32'd0);
        check("rst_wb_data", wb_data, 32'd0);
        rst = 1'b1;
        step();

        // Pass-through
        issue(32'h1234_5678, 32'h0, 3'b010, 1'b0, 1'b0, 5'd5, 1'b1);
        check("pt_done", 32'(done), 32'd1);
        check("pt_wb_data", wb_data, 32'h1234_5678);
        check("pt_wb_rd", 32'(wb_rd), 32'd5);
        check("pt_wb_we", 32'(wb_we), 32'd1);
        step();
        check("pt_done_clr", 32'(done), 32'd0);
        check("pt_busy_clr", 32'(busy), 32'd0);
        check("pt_no_req", 32'(req_cycles - req_base), 32'd0);

        // LB / LBU / LH with ready on the first ACCESS cycle
        dmem_rdata = 32'h80AA_BBCC;
        dmem_ready = 1'b1;
        issue(32'h0000_0103, 32'h0, 3'b000, 1'b1, 1'b0, 5'd7, 1'b1);
        check("lb_req", 32'(dmem_req), 32'd1);
        check("lb_addr", dmem_addr, 32'h0000_0100);
        check("lb_wstrb", 32'(dmem_wstrb), 32'd0);
        check("lb_we", 32'(dmem_we), 32'd0);
        check("lb_done_early", 32'(done), 32'd0);
        step();
        check("lb_done", 32'(done), 32'd1);
        check("lb_data", wb_data, 32'hFFFF_FF80);
        check("lb_wb_we", 32'(wb_we), 32'd1);
        check("lb_wb_rd", 32'(wb_rd), 32'd7);
        check("lb_req_drop", 32'(dmem_req), 32'd0);
        step();
        issue(32'h0000_0103, 32'h0, 3'b100, 1'b1, 1'b0, 5'd7, 1'b1);
        step();
        check("lbu_data", wb_data, 32'h0000_0080);
        step();
        issue(32'h0000_0102, 32'h0, 3'b001, 1'b1, 1'b0, 5'd8, 1'b1);
        step();
        check("lh_data", wb_data, 32'hFFFF_80AA);
        step();

        // SB lane 1
        issue(32'h0000_0001, 32'h0000_007F, 3'b000, 1'b0, 1'b1, 5'd1, 1'b0);
        check("sb_wdata", dmem_wdata, 32'h7F7F_7F7F);
        check("sb_wstrb", 32'(dmem_wstrb), 32'h2);
        check("sb_addr", dmem_addr, 32'h0);
        step();
        check("sb_done", 32'(done), 32'd1);
        step();

        // SH upper lane, three wait cycles
        dmem_ready = 1'b0;
        issue(32'h0000_0202, 32'hDEAD_BEEF, 3'b001, 1'b0, 1'b1, 5'd9, 1'b1);
        for (int i = 0; i < 4; i++) begin
            check("sh_req", 32'(dmem_req), 32'd1);
            check("sh_we", 32'(dmem_we), 32'd1);
            check("sh_wstrb", 32'(dmem_wstrb), 32'hC);
            check("sh_wdata", dmem_wdata, 32'hBEEF_BEEF);
            check("sh_addr", dmem_addr, 32'h0000_0200);
            if (i == 3) dmem_ready = 1'b1;
            step();
        end
        dmem_ready = 1'b0;
        check("sh_done", 32'(done), 32'd1);
        check("sh_wb_we", 32'(wb_we), 32'd0);
        check("sh_req_cycles", 32'(req_cycles - req_base), 32'd4);
        step();

        // Misaligned LW and illegal store funct3
        issue(32'h0000_0301, 32'h0, 3'b010, 1'b1, 1'b0, 5'd4, 1'b1);
        check("mis_done", 32'(done), 32'd1);
        check("mis_flag", 32'(misaligned), 32'd1);
        check("mis_err", 32'(bus_err), 32'd0);
        check("mis_wb_we", 32'(wb_we), 32'd0);
        step();
        check("mis_flag_clr", 32'(misaligned), 32'd0);
        check("mis_no_req", 32'(req_cycles - req_base), 32'd0);
        issue(32'h0000_0300, 32'h0, 3'b011, 1'b0, 1'b1, 5'd4, 1'b1);
        check("ill_done", 32'(done), 32'd1);
        check("ill_err", 32'(bus_err), 32'd1);
        check("ill_wb_we", 32'(wb_we), 32'd0);
        step();
        check("ill_no_req", 32'(req_cycles - req_base), 32'd0);

        // Timeout after four ACCESS cycles, then a normal LW
        issue(32'h0000_0400, 32'h0, 3'b010, 1'b1, 1'b0, 5'd6, 1'b1);
        repeat (4) step();
        check("to_done", 32'(done), 32'd1);
        check("to_err", 32'(bus_err), 32'd1);
        check("to_wb_we", 32'(wb_we), 32'd0);
        check("to_req_cycles", 32'(req_cycles - req_base), 32'd4);
        step();
        dmem_rdata = 32'h1122_3344;
        dmem_ready = 1'b1;
        issue(32'h0000_0404, 32'h0, 3'b010, 1'b1, 1'b0, 5'd6, 1'b1);
        step();
        check("post_to_data", wb_data, 32'h1122_3344);
        check("post_to_err", 32'(bus_err), 32'd0);
        step();

        // Reset during ACCESS
        dmem_ready = 1'b0;
        issue(32'h0000_0500, 32'h0, 3'b010, 1'b1, 1'b0, 5'd11, 1'b1);
        step();
        check("rm_req_before", 32'(dmem_req), 32'd1);
        done_base = done_pulses;
        #2 rst = 1'b0;
        #1;
        check("rm_req_async", 32'(dmem_req), 32'd0);
        check("rm_busy_async", 32'(busy), 32'd0);
        repeat (2) step();
        rst = 1'b1;
        step();
        check("rm_no_done", 32'(done_pulses - done_base), 32'd0);
        issue(32'h0000_00A5, 32'h0, 3'b000, 1'b0, 1'b0, 5'd3, 1'b1);
        check("rm_tick_done", 32'(done), 32'd1);
        check("rm_tick_rd", 32'(wb_rd), 32'd3);
        step();

        // Tick while busy is ignored
        issue(32'h0000_0600, 32'h0, 3'b010, 1'b1, 1'b0, 5'd10, 1'b1);
        rd_in = 5'd20; mem_read_in = 1'b0; alu_result_in = 32'h0; tick_exmem = 1'b1;
        step();
        tick_exmem = 1'b0;
        dmem_rdata = 32'hCAFE_F00D;
        dmem_ready = 1'b1;
        step();
        dmem_ready = 1'b0;
        check("busy_tick_done", 32'(done), 32'd1);
        check("busy_tick_rd", 32'(wb_rd), 32'd10);
        check("busy_tick_data", wb_data, 32'hCAFE_F00D);
        step();
        check("busy_tick_idle", 32'(busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Load/store stage directly downstream of the ALU in the multi-cycle core.
- Captures the ALU result (effective address or pass-through value), store data and memory control on the EX/MEM tick.
- Runs a req/ready transaction to data memory with byte/half/word alignment, store-strobe generation and load sign/zero extension.
- Presents one write-back result per captured instruction with a single-cycle done pulse.

Parameters:
- TIMEOUT_CYCLES, 255, ACCESS-state cycles without dmem_ready before the access aborts with bus_err (range 1..255, 8-bit counter).

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-low reset
- tick_exmem  in  1  capture strobe; honoured only in IDLE
- alu_result_in  in  32  address for loads/stores; result for non-memory ops
- rs2_data_in  in  32  store data
- funct3_in  in  3  access size/sign (RV32I encoding)
- mem_read_in  in  1  load
- mem_write_in  in  1  store
- rd_in  in  5  destination register
- reg_write_in  in  1  instruction writes rd
- dmem_req  out  1  memory request
- dmem_we  out  1  1=write, 0=read
- dmem_addr  out  32  word address, {addr[31:2],2'b00}
- dmem_wdata  out  32  lane-replicated store data
- dmem_wstrb  out  4  byte enables; 0000 on reads
- dmem_ready  in  1  request accepted/completed this cycle
- dmem_rdata  in  32  read word; valid when dmem_ready=1 on a read
- wb_data  out  32  write-back value
- wb_rd  out  5  write-back register
- wb_we  out  1  write-back enable; valid only while done=1
- done  out  1  one-cycle completion pulse
- busy  out  1  high in every state except IDLE
- misaligned  out  1  alignment fault; valid with done
- bus_err  out  1  timeout or illegal op; valid with done

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; all outputs 0; timeout counter 0. Reset asserted during ACCESS drops dmem_req immediately, with no completion.
- States: IDLE, ACCESS, DONE.
- IDLE + tick_exmem: register all *_in inputs, then classify:
  - Neither read nor write: -> DONE; wb_data=alu_result.
  - Read and write both set, load funct3 in {011,110,111}, or store funct3 >= 011: -> DONE with bus_err=1, no dmem_req.
  - Half access with addr[0]=1, or word access with addr[1:0]!=0: -> DONE with misaligned=1, no dmem_req.
  - Otherwise: -> ACCESS.
- tick_exmem outside IDLE: ignored. Upstream must not tick while busy=1.
- ACCESS:
  - dmem_req=1.
  - dmem_we, dmem_addr, dmem_wdata and dmem_wstrb are registered and held stable until the cycle dmem_ready=1 is sampled.
  - On dmem_ready=1: -> DONE; for loads, the extracted value is latched into wb_data.
  - The timeout counter increments each ACCESS cycle. When it reaches TIMEOUT_CYCLES without ready: drop req, -> DONE with bus_err=1.
  - Counter clears on ACCESS entry.
- Store formatting:
  - SB: wdata={4{b}}, wstrb=0001<<addr[1:0].
  - SH: wdata={2{h}}, wstrb=0011 (addr[1]=0) or 1100 (addr[1]=1).
  - SW: wdata=rs2, wstrb=1111.
- Load extraction: select byte lane addr[1:0] or half lane addr[1]. LB/LH sign-extend; LBU/LHU zero-extend; LW uses the full word.
- DONE:
  - done=1 for exactly one cycle.
  - wb_rd=rd; wb_we=reg_write & !misaligned & !bus_err. Stores never set wb_we even if reg_write=1.
  - -> IDLE.
- Outputs outside DONE: wb_we=0, done=0. misaligned and bus_err are 0 outside DONE. wb_data/wb_rd hold their last value.
- Latency:
  - Tick at cycle T.
  - Non-memory/fault: done at T+1.
  - Memory access: dmem_req from T+1; ready sampled at T+1+k (k>=0); done at T+2+k.
- dmem_ready while not in ACCESS: ignored.

Test Plan:
- Pass-through: tick, read=write=0, alu_result=0x1234_5678, rd=5, reg_write=1 -> done at T+1, wb_data=0x1234_5678, wb_rd=5, wb_we=1, dmem_req never asserted.
- LB with sign: addr=0x103, dmem_rdata=0x80AA_BBCC, ready on first ACCESS cycle -> dmem_addr=0x100, wstrb=0000, done at T+2, wb_data=0xFFFF_FF80. Repeat as LBU -> wb_data=0x0000_0080.
- SH upper lane: addr=0x202, rs2=0xDEAD_BEEF, ready after 3 wait cycles -> dmem_we=1, wstrb=1100, wdata=0xBEEF_BEEF, all held 4 cycles, done at T+5, wb_we=0.
- Misaligned LW: addr=0x301 -> done at T+1, misaligned=1, wb_we=0, no dmem_req. Illegal funct3=011 store -> bus_err=1, same timing.
- Timeout with TIMEOUT_CYCLES=4, ready held 0 -> dmem_req high exactly 4 cycles, then done with bus_err=1, wb_we=0. A following transaction completes normally.
- Reset mid-ACCESS: drop rst during wait -> dmem_req and busy go 0 asynchronously, no done pulse. After release, a tick is accepted in IDLE. A tick while busy is ignored: captured rd is unchanged.
